simon_cfg_key_loader: RTL and testbench

//  AXI4-Lite write initiator that loads a Simon key into the simon_cfg register block.

---
 rtl/simon_cfg_key_loader_pkg.sv | 17 +
 rtl/simon_cfg_key_loader_if.sv | 32 +++
 rtl/simon_cfg_key_loader.sv | 166 ++++++++++++++++
 tb/tb_simon_cfg_key_loader.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_cfg_key_loader_pkg.sv
// Shared constants and types for the simon_cfg key loader.
package simon_cfg_key_loader_pkg;

  localparam int unsigned SIMON_CFG_KEY_WORDS = 8;
  localparam int unsigned SIMON_CFG_START_IDX = 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  // Reported on done_resp when the B channel never answers
  localparam logic [1:0] LOADER_TIMEOUT_RESP = 2'b11;

endpackage

// File: rtl/simon_cfg_key_loader_if.sv
// AXI4-Lite write-only config bus between the key loader and simon_cfg.
interface simon_cfg_key_loader_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PROT_WIDTH = 1,
  parameter int unsigned RESP_WIDTH = 2,
  parameter int unsigned STRB_WIDTH = 4
);

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [PROT_WIDTH-1:0] awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [RESP_WIDTH-1:0] bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/simon_cfg_key_loader.sv
// Loads a whole Simon key into simon_cfg over AXI4-Lite, one 32-bit word per write,
// LSW first, optionally followed by a write of 1 to the start register.
module simon_cfg_key_loader
  import simon_cfg_key_loader_pkg::*;
#(
  parameter int unsigned KEYLEN_BYTES   = 32,
  parameter int unsigned CFG_DATA_WIDTH = 32,
  parameter int unsigned CFG_ADDR_WIDTH = 32,
  parameter int unsigned CFG_PROT_WIDTH = 1,
  parameter int unsigned CFG_RESP_WIDTH = 2,
  parameter int unsigned CFG_STRB_WIDTH = 4,
  parameter logic [CFG_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      key_req_valid,
  output logic                      key_req_ready,
  input  logic [KEYLEN_BYTES*8-1:0] key_req_data,
  input  logic                      key_req_kick,
  output logic                      done_valid,
  output logic                      done_err,
  output logic [CFG_RESP_WIDTH-1:0] done_resp,
  simon_cfg_key_loader_if.master    simon_cfg
);

  localparam int unsigned NWORDS = KEYLEN_BYTES / 4;
  localparam int unsigned IDX_W  = $clog2(NWORDS + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned KEY_W  = KEYLEN_BYTES * 8;

  typedef enum logic [1:0] {StIdle, StXfer, StResp, StDone} state_e;

  state_e                    state_q, state_d;
  logic [KEY_W-1:0]          shreg_q, shreg_d;
  logic                      kick_q, kick_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      aw_pend_q, aw_pend_d;
  logic                      w_pend_q, w_pend_d;
  logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
  logic                      done_valid_q, done_valid_d;
  logic                      done_err_q, done_err_d;
  logic [CFG_RESP_WIDTH-1:0] done_resp_q, done_resp_d;
  // Low only while in reset, so ready/bready stay low until the first clock after release
  logic                      active_q;

  logic [IDX_W-1:0]          nlast;
  logic                      aw_done;
  logic                      w_done;

  assign nlast = kick_q ? IDX_W'(NWORDS) : IDX_W'(NWORDS - 1);

  assign key_req_ready     = active_q && (state_q == StIdle);
  assign simon_cfg.awvalid = aw_pend_q;
  assign simon_cfg.wvalid  = w_pend_q;
  assign simon_cfg.awaddr  = BASE_ADDR + CFG_ADDR_WIDTH'({idx_q, 2'b00});
  assign simon_cfg.awprot  = '0;
  assign simon_cfg.wstrb   = '1;
  assign simon_cfg.wdata   = (idx_q == IDX_W'(NWORDS)) ? CFG_DATA_WIDTH'(1)
                                                       : shreg_q[CFG_DATA_WIDTH-1:0];
  // Idle also accepts B so stray responses are drained and ignored
  assign simon_cfg.bready  = active_q && ((state_q == StIdle) || (state_q == StResp));

  assign done_valid = done_valid_q;
  assign done_err   = done_err_q;
  assign done_resp  = done_resp_q;

  // A channel counts as finished if it already handshook or handshakes this cycle
  assign aw_done = !aw_pend_q || simon_cfg.awready;
  assign w_done  = !w_pend_q || simon_cfg.wready;

  // Next-state and datapath updates for the transfer sequencer
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    kick_d       = kick_q;
    idx_d        = idx_q;
    aw_pend_d    = aw_pend_q;
    w_pend_d     = w_pend_q;
    to_cnt_d     = to_cnt_q;
    done_valid_d = 1'b0;
    done_err_d   = 1'b0;
    done_resp_d  = '0;

    unique case (state_q)
      StIdle: begin
        if (key_req_valid && key_req_ready) begin
          shreg_d   = key_req_data;
          kick_d    = key_req_kick;
          idx_d     = '0;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          state_d   = StXfer;
        end
      end
      StXfer: begin
        if (aw_pend_q && simon_cfg.awready) aw_pend_d = 1'b0;
        if (w_pend_q && simon_cfg.wready) w_pend_d = 1'b0;
        if (aw_done && w_done) begin
          to_cnt_d = '0;
          state_d  = StResp;
        end
      end
      StResp: begin
        if (simon_cfg.bvalid) begin
          if (simon_cfg.bresp != CFG_RESP_WIDTH'(OKAY)) begin
            done_valid_d = 1'b1;
            done_err_d   = 1'b1;
            done_resp_d  = simon_cfg.bresp;
            state_d      = StDone;
          end else if (idx_q == nlast) begin
            done_valid_d = 1'b1;
            state_d      = StDone;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            shreg_d   = shreg_q >> CFG_DATA_WIDTH;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = StXfer;
          end
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          done_valid_d = 1'b1;
          done_err_d   = 1'b1;
          done_resp_d  = CFG_RESP_WIDTH'(LOADER_TIMEOUT_RESP);
          state_d      = StDone;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; reset drops every valid and strobe immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      kick_q       <= 1'b0;
      idx_q        <= '0;
      aw_pend_q    <= 1'b0;
      w_pend_q     <= 1'b0;
      to_cnt_q     <= '0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      done_resp_q  <= '0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      kick_q       <= kick_d;
      idx_q        <= idx_d;
      aw_pend_q    <= aw_pend_d;
      w_pend_q     <= w_pend_d;
      to_cnt_q     <= to_cnt_d;
      done_valid_q <= done_valid_d;
      done_err_q   <= done_err_d;
      done_resp_q  <= done_resp_d;
      active_q     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_simon_cfg_key_loader.sv
// Directed bench for simon_cfg_key_loader with a small AXI4-Lite write responder.
module tb_simon_cfg_key_loader;

  localparam int unsigned TO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_req_valid = 1'b0;
  logic         key_req_kick = 1'b0;
  logic [255:0] key_req_data = '0;
  logic         key_req_ready;
  logic         done_valid;
  logic         done_err;
  logic [1:0]   done_resp;

  always #5 clk = ~clk;

  simon_cfg_key_loader_if #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .PROT_WIDTH(1), .RESP_WIDTH(2), .STRB_WIDTH(4)
  ) bus ();

  simon_cfg_key_loader #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_req_valid (key_req_valid),
    .key_req_ready (key_req_ready),
    .key_req_data  (key_req_data),
    .key_req_kick  (key_req_kick),
    .done_valid    (done_valid),
    .done_err      (done_err),
    .done_resp     (done_resp),
    .simon_cfg     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Responder and monitor state
  int          cyc = 0;
  int          aw_delay = 0;
  int          aw_high = 0;
  int          w_high = 0;
  bit          aw_got = 0;
  bit          w_got = 0;
  bit          b_due = 0;
  bit          b_taken = 0;
  int          b_word = 0;
  int          err_word = -1;
  logic [1:0]  err_code = 2'b00;
  bit          withhold = 0;
  logic        resp_bvalid = 1'b0;
  logic [1:0]  resp_bresp = 2'b00;
  logic        inject_b = 1'b0;
  logic [31:0] aw_log[$];
  logic [31:0] w_log[$];
  int          aw_high_log[$];
  int          w_high_log[$];
  int          accept_cnt = 0;
  int          accept_cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          w_hs_cyc = 0;
  logic        done_err_s = 1'b0;
  logic [1:0]  done_resp_s = 2'b00;

  assign bus.bvalid = resp_bvalid | inject_b;
  assign bus.bresp  = resp_bresp;

  // Monitor: samples 1ns before each rising edge, when everything is settled
  always @(negedge clk) begin
    #4;
    cyc++;
    if (bus.awvalid) begin
      if (bus.awready) begin
        aw_log.push_back(bus.awaddr);
        aw_high_log.push_back(aw_high + 1);
        aw_high = 0;
        aw_got = 1;
      end else aw_high++;
    end
    if (bus.wvalid) begin
      if (bus.wready) begin
        w_log.push_back(bus.wdata);
        w_high_log.push_back(w_high + 1);
        w_high = 0;
        w_got = 1;
        w_hs_cyc = cyc;
      end else w_high++;
    end
    if (aw_got && w_got) begin
      b_due = 1;
      aw_got = 0;
      w_got = 0;
    end
    if (resp_bvalid && bus.bready) b_taken = 1;
    if (key_req_valid && key_req_ready) begin
      accept_cnt++;
      accept_cyc = cyc;
    end
    if (done_valid) begin
      done_cnt++;
      done_cyc = cyc;
      done_err_s = done_err;
      done_resp_s = done_resp;
    end
  end

  // Responder drive on the falling edge; B arrives the cycle after both AW and W
  always @(negedge clk) begin
    bus.awready = (aw_high >= aw_delay);
    bus.wready = 1'b1;
    if (b_taken) begin
      resp_bvalid = 1'b0;
      resp_bresp = 2'b00;
      b_taken = 0;
    end
    if (b_due) begin
      b_due = 0;
      if (!withhold) begin
        resp_bvalid = 1'b1;
        resp_bresp = (b_word == err_word) ? err_code : 2'b00;
      end
      b_word++;
    end
  end

  task automatic clear_logs();
    aw_log.delete();
    w_log.delete();
    aw_high_log.delete();
    w_high_log.delete();
    b_word = 0;
  endtask

  task automatic send_req(input logic [255:0] key, input logic kick);
    int prev;
    bit ok;
    @(negedge clk);
    key_req_valid = 1'b1;
    key_req_data = key;
    key_req_kick = kick;
    prev = accept_cnt;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (accept_cnt != prev) begin
        ok = 1;
        break;
      end
    end
    key_req_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept, expected accept");
    end
  endtask

  task automatic wait_done();
    int prev;
    bit ok;
    prev = done_cnt;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_cnt != prev) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done, expected done");
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (key_req_ready !== 1'b0 || bus.awvalid !== 1'b0 || bus.wvalid !== 1'b0 ||
        bus.bready !== 1'b0 || done_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b aw=%b w=%b b=%b dv=%b expected all 0",
               key_req_ready, bus.awvalid, bus.wvalid, bus.bready, done_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (key_req_ready !== 1'b1 || bus.bready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready: got rdy=%b bready=%b expected 1 1", key_req_ready, bus.bready);
    end
    checks++;
    if (bus.wstrb !== 4'hf || bus.awprot !== 1'b0) begin
      errors++;
      $display("FAIL strb_prot: got %h %b expected f 0", bus.wstrb, bus.awprot);
    end
  endtask

  task automatic test_basic();
    int a0;
    clear_logs();
    send_req(256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000, 1'b0);
    a0 = accept_cyc;
    wait_done();
    checks++;
    if (done_cyc - a0 !== 17) begin
      errors++;
      $display("FAIL basic_latency: got %0d expected 17", done_cyc - a0);
    end
    checks++;
    if (done_err_s !== 1'b0 || done_resp_s !== 2'b00) begin
      errors++;
      $display("FAIL basic_status: got err=%b resp=%b expected 0 00", done_err_s, done_resp_s);
    end
    checks++;
    if (aw_log.size() != 8 || w_log.size() != 8) begin
      errors++;
      $display("FAIL basic_count: got %0d/%0d expected 8/8", aw_log.size(), w_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (aw_log[i] !== 32'(4 * i) || w_log[i] !== 32'(i)) begin
          errors++;
          $display("FAIL basic_word%0d: got addr=%h data=%h expected %h %h",
                   i, aw_log[i], w_log[i], 32'(4 * i), 32'(i));
        end
      end
    end
  endtask

  task automatic test_kick();
    int a0;
    clear_logs();
    send_req(256'h11111117_11111116_11111115_11111114_11111113_11111112_11111111_11111110, 1'b1);
    a0 = accept_cyc;
    wait_done();
    checks++;
    if (done_cyc - a0 !== 19) begin
      errors++;
      $display("FAIL kick_latency: got %0d expected 19", done_cyc - a0);
    end
    checks++;
    if (done_err_s !== 1'b0) begin
      errors++;
      $display("FAIL kick_err: got %b expected 0", done_err_s);
    end
    checks++;
    if (aw_log.size() != 9 || w_log.size() != 9) begin
      errors++;
      $display("FAIL kick_count: got %0d/%0d expected 9/9", aw_log.size(), w_log.size());
    end else begin
      checks++;
      if (aw_log[8] !== 32'h20 || w_log[8] !== 32'h1) begin
        errors++;
        $display("FAIL kick_start: got addr=%h data=%h expected 20 1", aw_log[8], w_log[8]);
      end
      checks++;
      if (w_log[7] !== 32'h11111117) begin
        errors++;
        $display("FAIL kick_word7: got %h expected 11111117", w_log[7]);
      end
    end
  endtask

  task automatic test_aw_delay();
    logic [255:0] key;
    key = 256'hC0DE0777_C0DE0666_C0DE0555_C0DE0444_C0DE0333_C0DE0222_C0DE0111_C0DE0000;
    clear_logs();
    aw_delay = 2;
    send_req(key, 1'b0);
    wait_done();
    aw_delay = 0;
    checks++;
    if (aw_log.size() != 8 || w_log.size() != 8) begin
      errors++;
      $display("FAIL delay_count: got %0d/%0d expected 8/8", aw_log.size(), w_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (aw_high_log[i] !== 3 || w_high_log[i] !== 1 || w_log[i] !== key[i*32 +: 32] ||
            aw_log[i] !== 32'(4 * i)) begin
          errors++;
          $display("FAIL delay_word%0d: got awhi=%0d whi=%0d data=%h expected 3 1 %h",
                   i, aw_high_log[i], w_high_log[i], w_log[i], key[i*32 +: 32]);
        end
      end
    end
    checks++;
    if (done_err_s !== 1'b0) begin
      errors++;
      $display("FAIL delay_err: got %b expected 0", done_err_s);
    end
  endtask

  task automatic test_bresp_err();
    clear_logs();
    err_word = 3;
    err_code = 2'b10;
    send_req(256'h0, 1'b0);
    wait_done();
    err_word = -1;
    checks++;
    if (done_err_s !== 1'b1 || done_resp_s !== 2'b10) begin
      errors++;
      $display("FAIL berr_status: got err=%b resp=%b expected 1 10", done_err_s, done_resp_s);
    end
    checks++;
    if (aw_log.size() != 4) begin
      errors++;
      $display("FAIL berr_count: got %0d expected 4", aw_log.size());
    end
    clear_logs();
    send_req(256'h5, 1'b0);
    wait_done();
    checks++;
    if (done_err_s !== 1'b0 || aw_log.size() != 8) begin
      errors++;
      $display("FAIL berr_recover: got err=%b n=%0d expected 0 8", done_err_s, aw_log.size());
    end
  endtask

  task automatic test_timeout();
    int dprev;
    clear_logs();
    withhold = 1;
    send_req(256'h9, 1'b0);
    wait_done();
    withhold = 0;
    checks++;
    if (done_cyc - (w_hs_cyc + 1) !== 16) begin
      errors++;
      $display("FAIL to_latency: got %0d expected 16", done_cyc - (w_hs_cyc + 1));
    end
    checks++;
    if (done_err_s !== 1'b1 || done_resp_s !== 2'b11 || aw_log.size() != 1) begin
      errors++;
      $display("FAIL to_status: got err=%b resp=%b n=%0d expected 1 11 1",
               done_err_s, done_resp_s, aw_log.size());
    end
    dprev = done_cnt;
    @(negedge clk);
    inject_b = 1'b1;
    @(negedge clk);
    inject_b = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt !== dprev || key_req_ready !== 1'b1 || bus.awvalid !== 1'b0) begin
      errors++;
      $display("FAIL late_b: got dn=%0d rdy=%b aw=%b expected %0d 1 0",
               done_cnt, key_req_ready, bus.awvalid, dprev);
    end
  endtask

  task automatic test_reset_mid();
    int dprev;
    int a0;
    int aprev;
    bit seen;
    clear_logs();
    send_req(256'h77, 1'b0);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (aw_log.size() == 5 && bus.awvalid) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_reach_word5: got no word5 xfer, expected word5 xfer");
    end
    dprev = done_cnt;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.awvalid !== 1'b0 || bus.wvalid !== 1'b0 || key_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: got aw=%b w=%b rdy=%b expected 0 0 0",
               bus.awvalid, bus.wvalid, key_req_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt !== dprev) begin
      errors++;
      $display("FAIL rst_no_done: got %0d expected %0d", done_cnt, dprev);
    end
    clear_logs();
    send_req(256'hA, 1'b0);
    a0 = accept_cyc;
    // Second request is held through the whole first transfer
    aprev = accept_cnt;
    key_req_valid = 1'b1;
    key_req_data = 256'hB;
    key_req_kick = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (key_req_ready !== 1'b0 || accept_cnt !== aprev) begin
      errors++;
      $display("FAIL busy_hold: got rdy=%b acc=%0d expected 0 %0d",
               key_req_ready, accept_cnt, aprev);
    end
    wait_done();
    for (int i = 0; i < 20 && accept_cnt == aprev; i++) @(negedge clk);
    key_req_valid = 1'b0;
    checks++;
    if (accept_cyc - a0 !== 18) begin
      errors++;
      $display("FAIL busy_accept: got %0d expected 18", accept_cyc - a0);
    end
    wait_done();
    checks++;
    if (aw_log.size() != 16 || aw_log[0] !== 32'h0 || aw_log[8] !== 32'h0 ||
        w_log[0] !== 32'hA || w_log[8] !== 32'hB) begin
      errors++;
      $display("FAIL rst_restart: got n=%0d d0=%h d8=%h expected 16 a b",
               aw_log.size(), w_log[0], w_log[8]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_kick();
    test_aw_delay();
    test_bresp_err();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
